// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : ahb_arbiter
// Description: Round-robin AHB bus arbiter for up to NUM_MST masters. Tracks
//              fixed-length bursts, locked transfers and SPLIT masking to
//              decide when bus ownership may change; drives the HMASTER and
//              DefaultMst selects of the downstream master/slave mux.
// Ports      : HCLK, HRST_N (async, active-low)
//              HBUSREQ/HLOCKX  per-master request / lock (bits >= NUM_MST ignored)
//              HREADY/HTRANS/HBURST/HRESP/HSPLIT  muxed bus feedback
//              HGRANT      one-hot grant, zero when the default master is granted
//              HMASTER     address-phase owner index
//              DefaultMst  address phase owned by the internal default master
//              HMASTLOCK   current address phase is locked
// Revision   : 1.0 - initial release
// ============================================================================
module ahb_arbiter #(
    parameter int NUM_MST = 4
) (
    input  logic        HCLK,
    input  logic        HRST_N,
    input  logic [15:0] HBUSREQ,
    input  logic [15:0] HLOCKX,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HRESP,
    input  logic [15:0] HSPLIT,
    output logic [15:0] HGRANT,
    output logic [3:0]  HMASTER,
    output logic        DefaultMst,
    output logic        HMASTLOCK
);

    localparam logic [1:0]  C_TRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  C_TRANS_SEQ    = 2'b11;
    localparam logic [1:0]  C_RESP_OKAY    = 2'b00;
    localparam logic [1:0]  C_RESP_SPLIT   = 2'b11;
    // Bits of the 16-bit request vectors that belong to real masters.
    localparam logic [15:0] C_MST_VALID    = 16'((32'd1 << NUM_MST) - 32'd1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [4:0]  cnt_q,     cnt_d;      // beats remaining after the current one
    logic        gnt_vld_q, gnt_vld_d;  // a real master holds the grant
    logic [3:0]  gnt_idx_q, gnt_idx_d;  // index of the granted master
    logic [3:0]  mst_q,     mst_d;      // address-phase owner
    logic        dflt_q,    dflt_d;     // default master owns the address phase
    logic        mlock_q,   mlock_d;    // address phase is locked
    logic [15:0] mask_q,    mask_d;     // masters parked by a SPLIT response

    logic [15:0] w_elig;
    logic        w_lock_hold;
    logic        w_arb_ok;
    logic        w_rr_hit;
    logic [3:0]  w_rr_idx;
    logic [4:0]  w_cand;
    logic [4:0]  w_burst_load;
    logic [15:0] w_split_set;

    assign w_elig      = HBUSREQ & ~mask_q & C_MST_VALID;
    assign w_lock_hold = ~dflt_q & HLOCKX[mst_q];
    assign w_arb_ok    = (cnt_q == 5'd0) & ~w_lock_hold;

    // ------------------------------------------------------------------------
    // Beat counter: loaded with (beats-1) on the NONSEQ of a burst so that
    // arbitration stays frozen until the last beat has been accepted.
    // ------------------------------------------------------------------------
    always_comb begin
        case (HBURST)
            3'b010, 3'b011: w_burst_load = 5'd3;   // WRAP4 / INCR4
            3'b100, 3'b101: w_burst_load = 5'd7;   // WRAP8 / INCR8
            3'b110, 3'b111: w_burst_load = 5'd15;  // WRAP16 / INCR16
            default:        w_burst_load = 5'd0;   // SINGLE / INCR
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        // Any non-OKAY response ends the burst early, even mid-wait-state.
        if (HRESP != C_RESP_OKAY) begin
            cnt_d = 5'd0;
        end else if (HREADY) begin
            if (HTRANS == C_TRANS_NONSEQ) begin
                cnt_d = w_burst_load;
            end else if ((HTRANS == C_TRANS_SEQ) && (cnt_q != 5'd0)) begin
                cnt_d = cnt_q - 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin search starting one past the current owner. The owner is
    // the last candidate visited, so a sole eligible owner keeps the bus.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = mst_q;
        w_cand   = 5'd0;
        for (int k = 1; k <= NUM_MST; k++) begin
            w_cand = {1'b0, mst_q} + 5'(k);
            if (w_cand >= 5'(NUM_MST)) begin
                w_cand = w_cand - 5'(NUM_MST);
            end
            if (!w_rr_hit && w_elig[w_cand[3:0]]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = w_cand[3:0];
            end
        end
    end

    always_comb begin
        gnt_vld_d = gnt_vld_q;
        gnt_idx_d = gnt_idx_q;
        if (w_arb_ok) begin
            gnt_vld_d = w_rr_hit;
            if (w_rr_hit) begin
                gnt_idx_d = w_rr_idx;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Ownership handover happens only when the current transfer completes.
    // HMASTER keeps its last value while the default master owns the bus so
    // the round-robin pointer is preserved.
    // ------------------------------------------------------------------------
    always_comb begin
        mst_d   = mst_q;
        dflt_d  = dflt_q;
        mlock_d = mlock_q;
        if (HREADY) begin
            if (gnt_vld_q) begin
                mst_d = gnt_idx_q;
            end
            dflt_d  = ~gnt_vld_q;
            mlock_d = gnt_vld_q & HLOCKX[gnt_idx_q];
        end
    end

    // ------------------------------------------------------------------------
    // SPLIT mask: set on the first (wait) cycle of the two-cycle SPLIT
    // response; a simultaneous resume for the same master loses to the set.
    // ------------------------------------------------------------------------
    always_comb begin
        w_split_set = 16'h0000;
        if ((HRESP == C_RESP_SPLIT) && !HREADY && !dflt_q) begin
            w_split_set = 16'h0001 << mst_q;
        end
    end

    assign mask_d = ((mask_q & ~HSPLIT) | w_split_set) & C_MST_VALID;

    always_ff @(posedge HCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            cnt_q     <= 5'd0;
            gnt_vld_q <= 1'b0;
            gnt_idx_q <= 4'd0;
            mst_q     <= 4'd0;
            dflt_q    <= 1'b1;
            mlock_q   <= 1'b0;
            mask_q    <= 16'h0000;
        end else begin
            cnt_q     <= cnt_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_idx_q <= gnt_idx_d;
            mst_q     <= mst_d;
            dflt_q    <= dflt_d;
            mlock_q   <= mlock_d;
            mask_q    <= mask_d;
        end
    end

    assign HGRANT     = gnt_vld_q ? (16'h0001 << gnt_idx_q) : 16'h0000;
    assign HMASTER    = mst_q;
    assign DefaultMst = dflt_q;
    assign HMASTLOCK  = mlock_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_ahb_arbiter
// Description: Self-checking bench for ahb_arbiter. A driver applies directed
//              and random bus traffic, steps a behavioural reference model on
//              every clock edge and queues the expected outputs; a monitor
//              pops the queue on each falling edge and compares.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ahb_arbiter;

    localparam int N = 4;

    logic        HCLK = 1'b0;
    logic        HRST_N;
    logic [15:0] HBUSREQ, HLOCKX, HSPLIT;
    logic        HREADY;
    logic [1:0]  HTRANS, HRESP;
    logic [2:0]  HBURST;
    logic [15:0] HGRANT;
    logic [3:0]  HMASTER;
    logic        DefaultMst, HMASTLOCK;

    always #5 HCLK = ~HCLK;

    ahb_arbiter #(.NUM_MST(N)) dut (
        .HCLK       (HCLK),
        .HRST_N     (HRST_N),
        .HBUSREQ    (HBUSREQ),
        .HLOCKX     (HLOCKX),
        .HREADY     (HREADY),
        .HTRANS     (HTRANS),
        .HBURST     (HBURST),
        .HRESP      (HRESP),
        .HSPLIT     (HSPLIT),
        .HGRANT     (HGRANT),
        .HMASTER    (HMASTER),
        .DefaultMst (DefaultMst),
        .HMASTLOCK  (HMASTLOCK)
    );

    typedef struct packed {
        logic [15:0] gnt;
        logic [3:0]  mst;
        logic        dflt;
        logic        lock;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state, kept in plain integers.
    int m_owner;      // address-phase owner
    bit m_dflt;       // default master owns the bus
    bit m_lock;
    int m_gnt;        // granted master, -1 = default master
    int m_beats;      // beats still to come in the current burst
    bit m_split[N];   // masters parked by SPLIT

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = 0; m_dflt = 1'b1; m_lock = 1'b0; m_gnt = -1; m_beats = 0;
        for (int i = 0; i < N; i++) m_split[i] = 1'b0;
    endtask

    // Advance the model by one rising edge using the current bus inputs.
    task automatic model_step();
        int  nxt_gnt;
        bit  arb, park;
        exp_t e;
        if (!HRST_N) begin
            model_reset();
        end else begin
            arb     = (m_beats == 0) && !(!m_dflt && HLOCKX[m_owner]);
            park    = (HRESP == 2'b11) && !HREADY && !m_dflt;
            nxt_gnt = m_gnt;
            if (arb) begin
                nxt_gnt = -1;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_owner + k) % N;
                    if (HBUSREQ[c] && !m_split[c]) begin
                        nxt_gnt = c;
                        break;
                    end
                end
            end
            if (HRESP != 2'b00)                m_beats = 0;
            else if (HREADY && HTRANS == 2'b10) m_beats = burst_len(HBURST) - 1;
            else if (HREADY && HTRANS == 2'b11 && m_beats > 0) m_beats = m_beats - 1;
            for (int i = 0; i < N; i++) if (HSPLIT[i]) m_split[i] = 1'b0;
            if (park) m_split[m_owner] = 1'b1;
            if (HREADY) begin
                if (m_gnt >= 0) m_owner = m_gnt;
                m_dflt = (m_gnt < 0);
                m_lock = (m_gnt >= 0) && HLOCKX[m_gnt];
            end
            m_gnt = nxt_gnt;
        end
        e.gnt  = (m_gnt >= 0) ? (16'h0001 << m_gnt) : 16'h0000;
        e.mst  = 4'(m_owner);
        e.dflt = m_dflt;
        e.lock = m_lock;
        sb_q.push_back(e);
    endtask

    // One bus cycle: inputs change just after the falling edge, the model
    // steps on the rising edge.
    task automatic drive(input logic rstn, input logic [15:0] breq, input logic [15:0] lockx,
                         input logic rdy, input logic [1:0] trans, input logic [2:0] burst,
                         input logic [1:0] resp, input logic [15:0] hsplit);
        @(negedge HCLK);
        #1;
        HRST_N = rstn; HBUSREQ = breq; HLOCKX = lockx; HREADY = rdy;
        HTRANS = trans; HBURST = burst; HRESP = resp; HSPLIT = hsplit;
        @(posedge HCLK);
        model_step();
    endtask

    task automatic idle(input logic [15:0] breq, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, breq, 16'h0, 1'b1, 2'b00, 3'd0, 2'b00, 16'h0);
    endtask

    // Reset asserted between edges must take effect without a clock edge.
    task automatic async_reset_check();
        @(negedge HCLK);
        #1;
        HRST_N = 1'b0;
        #1;
        chk("async_rst_HGRANT",     32'(HGRANT),     32'h0);
        chk("async_rst_HMASTER",    32'(HMASTER),    32'h0);
        chk("async_rst_DefaultMst", 32'(DefaultMst), 32'h1);
        chk("async_rst_HMASTLOCK",  32'(HMASTLOCK),  32'h0);
        @(posedge HCLK);
        model_step();
    endtask

    // Monitor: outputs are registered, so every falling edge presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("HGRANT",     32'(HGRANT),     32'(e.gnt));
                chk("HMASTER",    32'(HMASTER),    32'(e.mst));
                chk("DefaultMst", 32'(DefaultMst), 32'(e.dflt));
                chk("HMASTLOCK",  32'(HMASTLOCK),  32'(e.lock));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        HRST_N = 1'b0; HBUSREQ = '0; HLOCKX = '0; HREADY = 1'b1;
        HTRANS = '0; HBURST = '0; HRESP = '0; HSPLIT = '0;

        // Reset held with random inputs, then released with no requests.
        for (int i = 0; i < 4; i++)
            drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom),
                  3'($urandom), 2'($urandom), 16'($urandom));
        idle(16'h0000, 3);

        // Single requester: grant, handover, release to default master.
        idle(16'h0004, 3);
        idle(16'h0000, 3);

        // Round robin over masters 0, 1 and 3 with SINGLE transfers.
        for (int i = 0; i < 10; i++) drive(1'b1, 16'h000B, 16'h0, 1'b1, 2'b10, 3'd0, 2'b00, 16'h0);
        idle(16'h0000, 2);

        // M1 runs an INCR4 with wait states while M0 requests.
        idle(16'h0002, 3);
        drive(1'b1, 16'h0002, 16'h0, 1'b1, 2'b10, 3'd3, 2'b00, 16'h0);
        drive(1'b1, 16'h0003, 16'h0, 1'b0, 2'b11, 3'd3, 2'b00, 16'h0);
        drive(1'b1, 16'h0003, 16'h0, 1'b0, 2'b11, 3'd3, 2'b00, 16'h0);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h0003, 16'h0, 1'b1, 2'b11, 3'd3, 2'b00, 16'h0);
        idle(16'h0003, 3);
        idle(16'h0000, 2);

        // Locked M2 keeps the bus until the lock is dropped.
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h0004, 16'h0004, 1'b1, 2'b00, 3'd0, 2'b00, 16'h0);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h0005, 16'h0004, 1'b1, 2'b10, 3'd0, 2'b00, 16'h0);
        idle(16'h0005, 3);
        idle(16'h0000, 2);

        // SPLIT on M1, then resume via HSPLIT.
        idle(16'h0002, 3);
        drive(1'b1, 16'h0003, 16'h0, 1'b0, 2'b10, 3'd0, 2'b11, 16'h0);
        drive(1'b1, 16'h0003, 16'h0, 1'b1, 2'b00, 3'd0, 2'b11, 16'h0);
        idle(16'h0003, 4);
        drive(1'b1, 16'h0003, 16'h0, 1'b1, 2'b00, 3'd0, 2'b00, 16'h0002);
        idle(16'h0003, 6);

        // SPLIT set and resume for the same master in one cycle: set wins.
        idle(16'h0002, 4);
        drive(1'b1, 16'h0002, 16'h0, 1'b0, 2'b10, 3'd0, 2'b11, 16'h0002);
        drive(1'b1, 16'h0002, 16'h0, 1'b1, 2'b00, 3'd0, 2'b11, 16'h0);
        idle(16'h0002, 4);
        drive(1'b1, 16'h0002, 16'h0, 1'b1, 2'b00, 3'd0, 2'b00, 16'h0002);
        idle(16'h0002, 3);

        // Reset in the middle of an INCR8 burst.
        drive(1'b1, 16'h0003, 16'h0, 1'b1, 2'b10, 3'd5, 2'b00, 16'h0);
        drive(1'b1, 16'h0003, 16'h0, 1'b1, 2'b11, 3'd5, 2'b00, 16'h0);
        async_reset_check();
        idle(16'h0000, 3);

        // Random traffic, upper request bits included.
        for (int i = 0; i < 2500; i++) begin
            logic        rstn, rdy;
            logic [15:0] lk, sp;
            logic [1:0]  resp;
            rstn = ($urandom_range(0, 199) != 0);
            rdy  = ($urandom_range(0, 3) != 0);
            lk   = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0;
            sp   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
            resp = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            drive(rstn, 16'($urandom), lk, rdy, 2'($urandom), 3'($urandom), resp, sp);
        end

        repeat (2) @(negedge HCLK);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
Round-robin AHB bus arbiter for up to NUM_MST masters. It sits directly upstream of the AHB master/slave mux and drives its HMASTER and DefaultMst select inputs. It tracks fixed-length bursts, locked transfers and SPLIT masking to decide when ownership may change. Bus signals (HTRANS, HBURST, HREADY, HRESP, HSPLIT) come back from the mux outputs.

Parameters:
NUM_MST, 4, number of real masters (1..16); HBUSREQ/HLOCKX bits at and above NUM_MST are ignored

Ports:
HCLK  input  1  clock
HRST_N  input  1  asynchronous active-low reset
HBUSREQ  input  16  per-master bus request
HLOCKX  input  16  per-master lock request
HREADY  input  1  muxed bus ready
HTRANS  input  2  muxed transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
HBURST  input  3  muxed burst type
HRESP  input  2  muxed response (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT)
HSPLIT  input  16  OR of slave split-resume vectors
HGRANT  output  16  one-hot grant, all zero when the default master owns the bus
HMASTER  output  4  address-phase owner index
DefaultMst  output  1  address-phase owner is the internal default master
HMASTLOCK  output  1  current address phase is locked

Behaviour:
- Reset: HRST_N is asynchronous, active-low; clock is HCLK. On reset: HGRANT=0, HMASTER=0, DefaultMst=1, HMASTLOCK=0, split mask=0, beat counter=0.
- Eligible request: elig[i] = HBUSREQ[i] & ~mask[i], for i < NUM_MST.
- Beat counter (5 bits), updated on the clock edge when HREADY=1:
  - HTRANS=NONSEQ: load beats-1. INCR4/WRAP4 -> 3, INCR8/WRAP8 -> 7, INCR16/WRAP16 -> 15, SINGLE/INCR -> 0.
  - HTRANS=SEQ and cnt!=0: decrement.
  - IDLE/BUSY: hold.
- HRESP != OKAY clears the counter to 0 regardless of HREADY. This covers early termination.
- lock_hold = ~DefaultMst & HLOCKX[HMASTER].
- Arbitration permitted: arb_ok = (cnt==0) & ~lock_hold.
- Grant register, updated every edge when arb_ok:
  - Search elig round-robin starting at (HMASTER+1) mod NUM_MST. The first hit gets HGRANT one-hot.
  - If the current owner is the only eligible master, it keeps the grant.
  - No eligible master: HGRANT=0 (default master).
  - When arb_ok=0, HGRANT holds.
- Ownership handover, on the edge with HREADY=1:
  - HMASTER <= index of HGRANT, or holds its value if HGRANT=0.
  - DefaultMst <= (HGRANT==0).
  - HMASTLOCK <= (HGRANT!=0) & HLOCKX[granted index].
  - With HREADY=0, all three hold.
- Latency: a request sampled at edge N gives HGRANT after N. HMASTER/DefaultMst update after the first HREADY=1 edge at or after N+1, so the minimum is 2 cycles.
- Split mask, per master:
  - Set mask[HMASTER] when HRESP=SPLIT & HREADY=0 & ~DefaultMst.
  - Clear mask[i] when HSPLIT[i]=1.
  - If set and clear hit the same bit in the same cycle, set wins.
  - A masked current owner loses its grant at the next permitted arbitration.
- RETRY and ERROR do not mask.
- If all requesters are masked, the default master is granted.
- Reset mid-burst: all state returns to reset values immediately. The in-flight burst is abandoned.

Test Plan:
1. Reset asserted with random inputs -> HGRANT=0000, HMASTER=0, DefaultMst=1, HMASTLOCK=0. Release with no requests -> values unchanged.
2. HBUSREQ=0004, HREADY=1 -> HGRANT=0004 after edge 1. After edge 2: HMASTER=2, DefaultMst=0. Drop request -> HGRANT=0, then DefaultMst=1.
3. HBUSREQ=000B held, SINGLE NONSEQ transfers, HREADY=1 -> grant sequence 0001, 0002, 0008, 0001 (master 2 skipped).
4. M1 owns the bus and issues INCR4 (NONSEQ + 3 SEQ) with 2 wait states while M0 requests -> HGRANT stays 0002 until the 4th beat is accepted, then 0001.
5. M2 with HLOCKX[2]=1 and HBUSREQ=0005 -> HMASTLOCK=1 and HGRANT stays 0004. Drop HLOCKX[2] -> grant moves to 0001.
6. M1 owner, HRESP=11 for 2 cycles (HREADY 0 then 1), HBUSREQ=0003 -> mask[1]=1, HGRANT=0001. Pulse HSPLIT[1] -> M1 is granted again at its next round-robin turn. Repeat with reset asserted mid-burst -> immediate return to reset values.
